// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path.
//   uart_state_t     : transmit sequencer state encoding
//   DEF_CLKS_PER_BIT : default bit period in clk cycles (50 MHz / 9600 baud)
//   DEF_DATA_BITS    : default data bits per frame
//   clog2()          : counter width helper, never returns less than 1
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int DEF_CLKS_PER_BIT = 5208;
    localparam int DEF_DATA_BITS    = 8;

    // Bits needed to hold the values 0..value-1.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// ---------------------------------------------------------------------------
// uart_baud_cnt
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps.
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_clear     : hold the count at 0
//   o_bit_done  : count is CLKS_PER_BIT-1 (last cycle of a bit period)
//   o_pre_done  : count is CLKS_PER_BIT-2 (one cycle before o_bit_done),
//                 lets the caller register a strobe that lands on bit_done
// ---------------------------------------------------------------------------
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    output logic o_bit_done,
    output logic o_pre_done
);

    localparam int CNT_W = clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] PRE  = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear || r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_bit_done = (r_count == LAST);
    assign o_pre_done = (r_count == PRE);

endmodule

// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
// UART transmit sequencer: one-deep holding buffer on the host side, drives
// an external piso serializer and builds start/data/stop frames on txd.
//   clk, rst_n   : clock, asynchronous active-low reset
//   tx_data      : byte from host, captured when tx_valid && tx_ready
//   tx_valid     : host presents tx_data
//   tx_ready     : holding buffer empty
//   piso_data    : byte to the piso, stable for the whole frame
//   piso_enable  : one-clk strobe, piso advances one bit per strobe
//   piso_serial  : piso serial output
//   piso_end     : piso end-of-data flag, checked against the bit count
//   txd          : registered serial line, idle high
//   tx_busy      : high while not in IDLE
//   frame_err    : one-clk pulse when piso_end disagrees with the bit count
// ---------------------------------------------------------------------------
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEF_DATA_BITS,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] piso_data,
    output logic                 piso_enable,
    input  logic                 piso_serial,
    input  logic                 piso_end,
    output logic                 txd,
    output logic                 tx_busy,
    output logic                 frame_err
);

    localparam int BIT_W = clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    uart_state_t          r_state;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0] r_buf;
    logic                 r_buf_full;
    logic [DATA_BITS-1:0] r_piso_data;
    logic                 r_piso_enable;
    logic                 r_txd;
    logic                 r_busy;
    logic                 r_frame_err;

    logic w_bit_done;
    logic w_pre_done;
    logic w_handshake;
    logic w_last_stop;
    logic w_load;
    logic w_end_expected;

    // Counter sits at 0 in IDLE so START always begins a full bit period;
    // every other state change happens on bit_done, where it wraps to 0.
    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (r_state == IDLE),
        .o_bit_done (w_bit_done),
        .o_pre_done (w_pre_done)
    );

    assign w_handshake    = tx_valid && !r_buf_full;
    assign w_last_stop    = (r_state == STOP) && w_bit_done && (r_bit_cnt == LAST_STOP);
    assign w_load         = r_buf_full && ((r_state == IDLE) || w_last_stop);
    assign w_end_expected = w_bit_done && (r_bit_cnt == LAST_DATA);

    // Holding buffer. Handshake and drain are mutually exclusive: the first
    // needs the buffer empty, the second needs it full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf      <= '0;
            r_buf_full <= 1'b0;
        end else if (w_handshake) begin
            r_buf      <= tx_data;
            r_buf_full <= 1'b1;
        end else if (w_load) begin
            r_buf_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_bit_cnt     <= '0;
            r_piso_data   <= '0;
            r_piso_enable <= 1'b0;
            r_txd         <= 1'b1;
            r_busy        <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            // Registered one cycle early so the strobe is visible on bit_done
            // and the piso presents the next bit from the first cycle of the
            // following bit period.
            r_piso_enable <= w_pre_done &&
                             ((r_state == START) ||
                              (r_state == DATA && r_bit_cnt != LAST_DATA));
            r_frame_err   <= (r_state == DATA) && (piso_end != w_end_expected);

            case (r_state)
                IDLE: begin
                    r_txd <= 1'b1;
                    if (w_load) begin
                        r_piso_data <= r_buf;
                        r_state     <= START;
                        r_busy      <= 1'b1;
                    end
                end
                START: begin
                    r_txd <= 1'b0;
                    if (w_bit_done) begin
                        r_state   <= DATA;
                        r_bit_cnt <= '0;
                    end
                end
                DATA: begin
                    r_txd <= piso_serial;
                    if (w_bit_done) begin
                        if (r_bit_cnt == LAST_DATA) begin
                            r_state   <= STOP;
                            r_bit_cnt <= '0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        end
                    end
                end
                STOP: begin
                    r_txd <= 1'b1;
                    if (w_bit_done) begin
                        if (r_bit_cnt == LAST_STOP) begin
                            r_bit_cnt <= '0;
                            // Queued byte goes straight out with no idle gap.
                            if (r_buf_full) begin
                                r_piso_data <= r_buf;
                                r_state     <= START;
                            end else begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_ready    = !r_buf_full;
    assign piso_data   = r_piso_data;
    assign piso_enable = r_piso_enable;
    assign txd         = r_txd;
    assign tx_busy     = r_busy;
    assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_ctrl
// Two sequencers with CLKS_PER_BIT=4: lane 0 with one stop bit, lane 1 with
// two. Each lane has a behavioural piso: every strobe presents the next bit
// LSB first, and end_of_data is high on the final cycle of the last bit.
// ---------------------------------------------------------------------------
module tb_uart_tx_ctrl;

    localparam int CPB = 4;
    localparam int DW  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] tx_data [2];
    logic [DW-1:0] piso_data [2];
    logic [1:0]    tx_valid;
    logic [1:0]    tx_ready;
    logic [1:0]    piso_enable;
    logic [1:0]    piso_serial;
    logic [1:0]    piso_end;
    logic [1:0]    txd;
    logic [1:0]    tx_busy;
    logic [1:0]    frame_err;
    logic [1:0]    force_end;

    int pk [2];
    int since [2];
    int strobe_cnt [2];
    int busy_cnt [2];
    int ferr_cnt [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_lane
        uart_tx_ctrl #(
            .CLKS_PER_BIT(CPB),
            .DATA_BITS   (DW),
            .STOP_BITS   (g + 1)
        ) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .tx_data    (tx_data[g]),
            .tx_valid   (tx_valid[g]),
            .tx_ready   (tx_ready[g]),
            .piso_data  (piso_data[g]),
            .piso_enable(piso_enable[g]),
            .piso_serial(piso_serial[g]),
            .piso_end   (piso_end[g]),
            .txd        (txd[g]),
            .tx_busy    (tx_busy[g]),
            .frame_err  (frame_err[g])
        );
    end

    // piso model for both lanes
    always @(posedge clk or negedge rst_n) begin
        for (int g = 0; g < 2; g++) begin
            if (!rst_n) begin
                pk[g]          <= 0;
                since[g]       <= 0;
                piso_serial[g] <= 1'b0;
            end else if (piso_enable[g]) begin
                if (pk[g] == DW) begin
                    piso_serial[g] <= piso_data[g][0];
                    pk[g]          <= 1;
                end else begin
                    piso_serial[g] <= piso_data[g][pk[g]];
                    pk[g]          <= pk[g] + 1;
                end
                since[g] <= 0;
            end else if (since[g] < 1000) begin
                since[g] <= since[g] + 1;
            end
        end
    end

    always_comb begin
        for (int g = 0; g < 2; g++) begin
            piso_end[g] = ((pk[g] == DW) && (since[g] == CPB - 1)) || force_end[g];
        end
    end

    // Event counters, sampled away from the active edge.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            strobe_cnt[g] <= strobe_cnt[g] + int'(piso_enable[g]);
            busy_cnt[g]   <= busy_cnt[g] + int'(tx_busy[g]);
            ferr_cnt[g]   <= ferr_cnt[g] + int'(frame_err[g]);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Handshake one byte, then wait for txd to fall. Returns the number of
    // negedges from the handshake edge to the first low sample; leaves the
    // caller on that sample (first cycle of the start bit on txd).
    task automatic send(input int g, input logic [7:0] d, output int lat);
        int n;
        @(negedge clk);
        tx_data[g]  = d;
        tx_valid[g] = 1'b1;
        n = 0;
        while (tx_ready[g] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("send_ready_wait", 32'(n < 200), 32'd1);
        @(negedge clk);
        tx_valid[g] = 1'b0;
        lat = 1;
        while (txd[g] !== 1'b0 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Mid-bit samples of txd starting from the first start-bit sample.
    // force_at: after this sample, hold piso_end high for one cycle.
    task automatic capture(input int g, input int nbits, input int force_at,
                           output logic [31:0] bits);
        int gap;
        bits = '0;
        gap  = 2;
        for (int i = 0; i < nbits; i++) begin
            repeat (gap) @(negedge clk);
            bits[i] = txd[g];
            gap = 4;
            if (i == force_at) begin
                force_end[g] = 1'b1;
                @(negedge clk);
                force_end[g] = 1'b0;
                gap = 3;
            end
        end
    endtask

    task automatic wait_idle(input int g);
        int n;
        n = 0;
        while (tx_busy[g] !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", 32'(n < 500), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int          lat;
        int          s0, b0, f0, n;
        logic [31:0] bits;

        tx_valid   = '0;
        force_end  = '0;
        tx_data[0] = '0;
        tx_data[1] = '0;

        // Reset and idle behaviour
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_txd",       32'(txd),         32'h3);
        check("rst_ready",     32'(tx_ready),    32'h3);
        check("rst_busy",      32'(tx_busy),     32'h0);
        check("rst_enable",    32'(piso_enable), 32'h0);
        check("rst_frame_err", 32'(frame_err),   32'h0);
        check("rst_piso_data", 32'(piso_data[0]), 32'h0);
        s0 = strobe_cnt[0] + strobe_cnt[1];
        repeat (100) @(negedge clk);
        check("idle_strobes", 32'(strobe_cnt[0] + strobe_cnt[1] - s0), 32'd0);
        check("idle_txd",     32'(txd), 32'h3);

        // Single frame 8'hD4
        s0 = strobe_cnt[0]; b0 = busy_cnt[0]; f0 = ferr_cnt[0];
        send(0, 8'hD4, lat);
        check("d4_latency", 32'(lat), 32'd3);
        capture(0, 10, -1, bits);
        check("d4_bits", bits, {22'd0, 1'b1, 8'hD4, 1'b0});
        wait_idle(0);
        check("d4_strobes",   32'(strobe_cnt[0] - s0), 32'd8);
        check("d4_frame_len", 32'(busy_cnt[0] - b0),   32'd40);
        check("d4_frame_err", 32'(ferr_cnt[0] - f0),   32'd0);

        // Back-to-back 8'h55 then 8'hA3 queued during the first frame
        s0 = strobe_cnt[0]; b0 = busy_cnt[0];
        send(0, 8'h55, lat);
        fork
            capture(0, 20, -1, bits);
            begin
                repeat (10) @(negedge clk);
                check("b2b_ready_before", 32'(tx_ready[0]), 32'd1);
                tx_data[0]  = 8'hA3;
                tx_valid[0] = 1'b1;
                @(negedge clk);
                tx_valid[0] = 1'b0;
                check("b2b_ready_low", 32'(tx_ready[0]), 32'd0);
                repeat (25) @(negedge clk);
                check("b2b_ready_held", 32'(tx_ready[0]), 32'd0);
                repeat (8) @(negedge clk);
                check("b2b_ready_after_load", 32'(tx_ready[0]), 32'd1);
            end
        join
        check("b2b_bits", bits, {12'd0, 1'b1, 8'hA3, 1'b0, 1'b1, 8'h55, 1'b0});
        wait_idle(0);
        check("b2b_busy_len", 32'(busy_cnt[0] - b0),   32'd80);
        check("b2b_strobes",  32'(strobe_cnt[0] - s0), 32'd16);

        // Two stop bits, 8'h00
        b0 = busy_cnt[1]; f0 = ferr_cnt[1];
        send(1, 8'h00, lat);
        n = 1;
        while (txd[1] === 1'b0 && n < 100) begin
            @(negedge clk);
            if (txd[1] === 1'b0) n++;
        end
        check("stop2_low_run", 32'(n), 32'd36);
        n = 1;
        repeat (7) begin
            @(negedge clk);
            if (txd[1] === 1'b1) n++;
        end
        check("stop2_high_run", 32'(n), 32'd8);
        check("stop2_idle",     32'(tx_busy[1]), 32'd0);
        wait_idle(1);
        check("stop2_busy_len",  32'(busy_cnt[1] - b0), 32'd44);
        check("stop2_frame_err", 32'(ferr_cnt[1] - f0), 32'd0);

        // Reset during data bit 3 of 8'h00
        send(0, 8'h00, lat);
        capture(0, 5, -1, bits);
        check("rstmid_low_before", 32'(txd[0]), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_txd",   32'(txd[0]),      32'd1);
        check("rstmid_ready", 32'(tx_ready[0]), 32'd1);
        check("rstmid_busy",  32'(tx_busy[0]),  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        s0 = strobe_cnt[0];
        send(0, 8'hFF, lat);
        check("ff_latency", 32'(lat), 32'd3);
        capture(0, 10, -1, bits);
        check("ff_bits", bits, {22'd0, 1'b1, 8'hFF, 1'b0});
        wait_idle(0);
        check("ff_strobes", 32'(strobe_cnt[0] - s0), 32'd8);

        // piso_end forced high for one cycle during data bit 2
        f0 = ferr_cnt[0];
        send(0, 8'h5A, lat);
        capture(0, 10, 3, bits);
        check("ferr_bits", bits, {22'd0, 1'b1, 8'h5A, 1'b0});
        wait_idle(0);
        check("ferr_pulses", 32'(ferr_cnt[0] - f0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
